demux8_16bit_reg: RTL
=====================

Name: demux8_16bit_reg

Overview:
- Registered 1-to-8, 16-bit demultiplexer. It is the write-side counterpart of mux8_16bit.
- A single 16-bit word `in` is steered by select `s` into one of eight held output registers, out0..out7, under a valid/ready handshake.
- Provides per-output valid flags and one-cycle update strobes.
- Provides a sequential clear sweep. The block sits in the CPU datapath as the write port feeding mux8_16bit read selection.

Parameters:
- WIDTH, 16, data width of `in` and out0..out7.
- CLR_INIT, 1, if 1 the block enters the CLEAR sweep on the first clock after reset release; if 0 it enters IDLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  write data
- s  input  3  destination select, 0..7
- wr_valid  input  1  write request
- wr_ready  output  1  block can accept a write this cycle
- clr  input  1  request clear sweep of all outputs
- out0..out7  output  WIDTH each  held output registers
- vld  output  8  vld[i]=1 when out_i holds a written, uncleared value
- upd  output  8  one-cycle strobe; upd[i]=1 the cycle after out_i is written
- busy  output  1  high while the CLEAR sweep runs

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - out0..out7=0, vld=0, upd=0, busy=0, sweep counter cnt=0.
  - State goes to RST_HOLD. wr_ready=0 while rst_n=0.
- First clk edge after rst_n rises: go to CLEAR if CLR_INIT=1, else to IDLE.
- States: RST_HOLD, IDLE, CLEAR.
- wr_ready = (state==IDLE) && !clr. It is combinational from state and clr.
- Write acceptance: on a clk edge with wr_valid && wr_ready:
  - out_s <= in and vld[s] <= 1.
  - upd becomes a one-hot vector with bit s set, for exactly one cycle.
  - Latency: write to visible output is 1 cycle.
- Back-to-back writes are allowed every cycle. Repeated writes to the same s overwrite the value and pulse upd[s] each time.
- upd defaults to 0 on any cycle with no accepted write.
- Outputs not selected hold their value.
- IDLE + clr=1:
  - No write is accepted that cycle, since wr_ready=0, so clr wins over a simultaneous wr_valid.
  - Next state is CLEAR with cnt=0.
- CLEAR:
  - busy=1 and wr_ready=0.
  - Each cycle out_cnt <= 0, vld[cnt] <= 0, cnt <= cnt+1.
  - After clearing index 7, cnt wraps to 0 and the state returns to IDLE.
  - The sweep takes exactly 8 cycles. busy falls on the edge that clears index 7.
- clr asserted during CLEAR is ignored; the sweep is not restarted.
- clr held high across the CLEAR→IDLE transition starts a new sweep on the next cycle, because IDLE sees clr=1.
- wr_valid asserted while wr_ready=0 is not accepted. The source must hold in, s and wr_valid until the handshake completes.
- rst_n asserted mid-sweep or mid-write aborts immediately. All outputs take their reset values asynchronously.
- X on s while wr_valid=0 has no effect.

Optional Feature:
- Macro: DEMUX8_RDBACK_EN.
- Defined:
  - Adds input rd_s (3 bits) and output rd_data (WIDTH bits).
  - rd_data = out_{rd_s}, combinationally.
  - Write-through forwarding: if wr_valid && wr_ready && s==rd_s in the same cycle, rd_data = in.
  - rd_data is 0 during reset.
- Undefined: rd_s and rd_data ports do not exist. The core behaviour is unchanged.

Test Plan:
1. Reset, CLR_INIT=0: rst_n=0 then released, no other stimulus -> out0..out7=0x0000, vld=8'h00, busy=0; wr_ready=1 on the cycle after release.
2. Write 0xA5A5 with s=3, then 0x1234 with s=7 on consecutive cycles -> out3=0xA5A5, out7=0x1234, vld=8'h88; upd=8'h08 then 8'h80, one cycle each; other outputs remain 0.
3. Write all eight indices with values 0x1111*i, then pulse clr -> busy high for exactly 8 cycles, wr_ready=0 throughout; out_i returns to 0 in index order 0..7 (one index per cycle); vld ends at 8'h00.
4. clr=1 and wr_valid=1 with s=2 and in=0xBEEF in the same IDLE cycle -> write rejected, out2 unchanged, CLEAR entered; after 8 cycles, re-present the write -> out2=0xBEEF.
5. rst_n dropped on the 4th CLEAR cycle after out0..out7 were loaded with 0xFFFF -> all outputs 0 immediately (asynchronous), busy=0; after release with CLR_INIT=1 -> busy=1 for 8 cycles.
6. With DEMUX8_RDBACK_EN defined: rd_s=5, out5=0x00FF; write 0x7E7E with s=5 -> rd_data=0x7E7E in the same cycle (forwarded) and on the following cycle (registered); rd_s=6 -> rd_data=out6.

Source files
------------

// File: rtl/demux8_16bit_reg_if.sv
// demux8_16bit_reg_if: write/read bus of the registered 1-to-8 demultiplexer.
//   master (source side): drives in, s, wr_valid, clr; observes wr_ready,
//                         out0..out7, vld, upd, busy.
//   slave  (demux side) : the mirror image.
// Optional macro DEMUX8_RDBACK_EN adds rd_s (master->slave) and rd_data
// (slave->master) for combinational read-back with write-through forwarding.
interface demux8_16bit_reg_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic [2:0]       s;
  logic             wr_valid;
  logic             wr_ready;
  logic             clr;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic [WIDTH-1:0] out5;
  logic [WIDTH-1:0] out6;
  logic [WIDTH-1:0] out7;
  logic [7:0]       vld;
  logic [7:0]       upd;
  logic             busy;
`ifdef DEMUX8_RDBACK_EN
  logic [2:0]       rd_s;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output in, s, wr_valid, clr, rd_s,
    input  wr_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           vld, upd, busy, rd_data
  );

  modport slave (
    input  in, s, wr_valid, clr, rd_s,
    output wr_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           vld, upd, busy, rd_data
  );
`else
  modport master (
    output in, s, wr_valid, clr,
    input  wr_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           vld, upd, busy
  );

  modport slave (
    input  in, s, wr_valid, clr,
    output wr_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           vld, upd, busy
  );
`endif
endinterface

// File: rtl/demux8_16bit_reg.sv
// demux8_16bit_reg: registered 1-to-8 demultiplexer, write-side counterpart
// of mux8_16bit. A word on bus.in is steered by bus.s into one of eight held
// output registers under a valid/ready handshake, with per-output valid
// flags, one-cycle update strobes and a sequential 8-cycle clear sweep.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    demux8_16bit_reg_if.slave:
//          in/s/wr_valid -> write request, wr_ready <- accept this cycle
//          clr           -> start clear sweep (wins over a same-cycle write)
//          out0..out7    <- held output registers
//          vld/upd       <- per-output valid flags / one-cycle write strobes
//          busy          <- clear sweep in progress
//
// Parameters:
//   WIDTH    data width (must match the interface WIDTH)
//   CLR_INIT 1: run a clear sweep right after reset release; 0: go idle
//
// Optional macro DEMUX8_RDBACK_EN: enables rd_s/rd_data read-back, where
// rd_data = out[rd_s], forwarded from bus.in on a same-cycle accepted write.
module demux8_16bit_reg #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          CLR_INIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux8_16bit_reg_if.slave    bus
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    IDLE     = 2'd1,
    CLEAR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] out_q [8];
  logic [WIDTH-1:0] out_d [8];
  logic [7:0]       vld_q,   vld_d;
  logic [7:0]       upd_q,   upd_d;

  logic wr_ready;
  logic wr_accept;

  // clr blocks acceptance so a simultaneous write is never half-applied
  // before the sweep starts.
  assign wr_ready  = (state_q == IDLE) && !bus.clr;
  assign wr_accept = bus.wr_valid && wr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    upd_d   = '0;
    case (state_q)
      RST_HOLD: begin
        cnt_d   = '0;
        state_d = CLR_INIT ? CLEAR : IDLE;
      end
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr_accept) begin
          out_d[bus.s] = bus.in;
          vld_d[bus.s] = 1'b1;
          upd_d[bus.s] = 1'b1;
        end
      end
      CLEAR: begin
        out_d[cnt_q] = '0;
        vld_d[cnt_q] = 1'b0;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      out_q   <= '{default: '0};
      vld_q   <= '0;
      upd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      upd_q   <= upd_d;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.busy     = (state_q == CLEAR);
  assign bus.vld      = vld_q;
  assign bus.upd      = upd_q;
  assign bus.out0     = out_q[0];
  assign bus.out1     = out_q[1];
  assign bus.out2     = out_q[2];
  assign bus.out3     = out_q[3];
  assign bus.out4     = out_q[4];
  assign bus.out5     = out_q[5];
  assign bus.out6     = out_q[6];
  assign bus.out7     = out_q[7];

`ifdef DEMUX8_RDBACK_EN
  // Forward the incoming word when it targets the read-back index so the
  // reader never sees the stale value during the write cycle.
  assign bus.rd_data = !rst_n                             ? '0 :
                       (wr_accept && (bus.s == bus.rd_s)) ? bus.in :
                                                            out_q[bus.rd_s];
`endif

endmodule
